// File: rtl/s_axis_pkt.sv
// AXI4-Stream slave into a first-word-fall-through beat FIFO storing {tlast, tkeep, tdata}.
// Optional packet mode (define S_AXIS_PKT_MODE_EN) holds beats back until a whole packet is stored.
module s_axis_pkt #(
  parameter int S_AXIS_DATA_BYTES = 8,
  parameter int FIFO_DEPTH        = 64,
  parameter int FIFO_AW           = 6,
  parameter int AFULL_LVL         = 56
) (
  input  logic                           s_axis_aclk,
  input  logic                           s_axis_aresetn,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  input  logic [8*S_AXIS_DATA_BYTES-1:0] s_axis_tdata,
  input  logic [S_AXIS_DATA_BYTES-1:0]   s_axis_tstrb,
  input  logic [S_AXIS_DATA_BYTES-1:0]   s_axis_tkeep,
  output logic                           s_axis_tready,
  input  logic                           u_fifo_ren,
  output logic                           u_fifo_rready,
  output logic [8*S_AXIS_DATA_BYTES-1:0] u_fifo_rdata,
  output logic [S_AXIS_DATA_BYTES-1:0]   u_fifo_rkeep,
  output logic                           u_fifo_rlast,
  output logic [FIFO_AW:0]               u_fifo_level,
  output logic                           u_fifo_afull,
  output logic                           u_rd_err
);

  localparam int DW = 8 * S_AXIS_DATA_BYTES;
  localparam int EW = DW + S_AXIS_DATA_BYTES + 1;
  localparam logic [FIFO_AW:0] PTR_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0] AFULL_TH = (FIFO_AW+1)'(AFULL_LVL);

  // Handshakes: a beat transfers on an edge where valid & ready are both high;
  // ready never depends on valid, so upstream may wait for ready before asserting valid.

  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic [FIFO_AW:0] level;
  logic             rst_done;
  logic             rd_err;
  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [EW-1:0]    head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             rready;
  logic             unused_tstrb;

  assign unused_tstrb = ^s_axis_tstrb;

  // Pointer MSB is the wrap bit: equal low bits with differing MSB means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  // rst_done keeps tready low while reset is held and raises it one edge after release.
  assign s_axis_tready = rst_done & ~full;
  assign push          = s_axis_tvalid & s_axis_tready;
  assign pop           = u_fifo_ren & rready;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      level <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level <= level + PTR_ONE;
        2'b01:   level <= level - PTR_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      rd_err <= 1'b0;
    end else if (u_fifo_ren && !rready) begin
      rd_err <= 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge s_axis_aclk) begin
    if (push) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    end
  end

  assign head = mem[rd_ptr[FIFO_AW-1:0]];

`ifdef S_AXIS_PKT_MODE_EN
  logic [FIFO_AW:0] pkt_cnt;
  logic             pkt_in;
  logic             pkt_out;

  assign pkt_in  = push & s_axis_tlast;
  assign pkt_out = pop & head[EW-1];

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      pkt_cnt <= '0;
    end else begin
      case ({pkt_in, pkt_out})
        2'b10:   pkt_cnt <= pkt_cnt + PTR_ONE;
        2'b01:   pkt_cnt <= pkt_cnt - PTR_ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // A full FIFO without any tlast would otherwise never drain, so full also releases beats.
  assign rready = ~empty & ((pkt_cnt != '0) | full);
`else
  assign rready = ~empty;
`endif

  assign u_fifo_rready = rready;
  assign u_fifo_rdata  = head[DW-1:0];
  assign u_fifo_rkeep  = head[DW +: S_AXIS_DATA_BYTES];
  assign u_fifo_rlast  = head[EW-1];
  assign u_fifo_level  = level;
  assign u_fifo_afull  = (level >= AFULL_TH);
  assign u_rd_err      = rd_err;

endmodule

// File: tb/tb_s_axis_pkt.sv
// Directed bench for s_axis_pkt: a hand-computed vector table plus multi-cycle sequences
// checked against a beat queue model (full, wrap, steady level, packet gating, mid-packet reset).
module tb_s_axis_pkt;

  localparam int DEPTH = 64;
  localparam int AFULL = 56;
  localparam int W     = 73;
`ifdef S_AXIS_PKT_MODE_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tstrb;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tready;
  logic        u_fifo_ren;
  logic        u_fifo_rready;
  logic [63:0] u_fifo_rdata;
  logic [7:0]  u_fifo_rkeep;
  logic        u_fifo_rlast;
  logic [6:0]  u_fifo_level;
  logic        u_fifo_afull;
  logic        u_rd_err;

  s_axis_pkt dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tstrb   (s_axis_tstrb),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tready  (s_axis_tready),
    .u_fifo_ren     (u_fifo_ren),
    .u_fifo_rready  (u_fifo_rready),
    .u_fifo_rdata   (u_fifo_rdata),
    .u_fifo_rkeep   (u_fifo_rkeep),
    .u_fifo_rlast   (u_fifo_rlast),
    .u_fifo_level   (u_fifo_level),
    .u_fifo_afull   (u_fifo_afull),
    .u_rd_err       (u_rd_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic         m_err = 1'b0;

  typedef struct {
    logic        v;
    logic        l;
    logic [63:0] d;
    logic [7:0]  k;
    logic        r;
    logic        e_tready;
    logic        e_rready;
    logic [6:0]  e_level;
    logic        e_err;
    logic [63:0] e_d;
    logic [7:0]  e_k;
    logic        e_l;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic v, logic l, logic [63:0] d, logic [7:0] k, logic r,
                              logic tr, logic rr, logic [6:0] lv, logic er,
                              logic [63:0] hd, logic [7:0] hk, logic hl);
    vec_t t;
    t.v = v; t.l = l; t.d = d; t.k = k; t.r = r;
    t.e_tready = tr; t.e_rready = rr; t.e_level = lv; t.e_err = er;
    t.e_d = hd; t.e_k = hk; t.e_l = hl;
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [63:0] d,
                       input logic [7:0] k, input logic r);
    s_axis_tvalid = v;
    s_axis_tlast  = l;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tstrb  = ~k;
    u_fifo_ren    = r;
  endtask

  // one cycle: drive at negedge, check the pre-edge state against the queue model, update model
  task automatic step(input logic v, input logic l, input logic [63:0] d,
                      input logic [7:0] k, input logic r);
    int   npk;
    logic m_tr;
    logic m_rr;
    @(negedge clk);
    drive(v, l, d, k, r);
    #1;
    npk = 0;
    foreach (exp_q[i]) if (exp_q[i][72]) npk++;
    m_tr = (exp_q.size() < DEPTH);
    m_rr = (exp_q.size() != 0) && (!PKT || npk != 0 || exp_q.size() == DEPTH);
    check("level",  128'(u_fifo_level),  128'(exp_q.size()));
    check("tready", 128'(s_axis_tready), 128'(m_tr));
    check("rready", 128'(u_fifo_rready), 128'(m_rr));
    check("afull",  128'(u_fifo_afull),  128'(exp_q.size() >= AFULL));
    check("rd_err", 128'(u_rd_err),      128'(m_err));
    if (r && m_rr) begin
      check("head", 128'({u_fifo_rlast, u_fifo_rkeep, u_fifo_rdata}), 128'(exp_q[0]));
      void'(exp_q.pop_front());
    end
    if (r && !m_rr) m_err = 1'b1;
    if (v && m_tr) exp_q.push_back({l, k, d});
    @(posedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) step(1'b0, 1'b0, 64'd0, 8'd0, 1'b1);
    step(1'b0, 1'b0, 64'd0, 8'd0, 1'b0);
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 64'h11, 8'hFF, 0, 1, 0,    7'd0, 0, 64'h0,  8'h00, 0);
    vecs[1]  = mk(1, 0, 64'h22, 8'h0F, 0, 1, !PKT, 7'd1, 0, 64'h11, 8'hFF, 0);
    vecs[2]  = mk(1, 1, 64'h33, 8'h01, 0, 1, !PKT, 7'd2, 0, 64'h11, 8'hFF, 0);
    vecs[3]  = mk(0, 0, 64'h0,  8'h00, 0, 1, 1,    7'd3, 0, 64'h11, 8'hFF, 0);
    vecs[4]  = mk(0, 0, 64'h0,  8'h00, 1, 1, 1,    7'd3, 0, 64'h11, 8'hFF, 0);
    vecs[5]  = mk(0, 0, 64'h0,  8'h00, 1, 1, 1,    7'd2, 0, 64'h22, 8'h0F, 0);
    vecs[6]  = mk(0, 0, 64'h0,  8'h00, 1, 1, 1,    7'd1, 0, 64'h33, 8'h01, 1);
    vecs[7]  = mk(0, 0, 64'h0,  8'h00, 1, 1, 0,    7'd0, 0, 64'h0,  8'h00, 0);
    vecs[8]  = mk(0, 0, 64'h0,  8'h00, 0, 1, 0,    7'd0, 1, 64'h0,  8'h00, 0);
    vecs[9]  = mk(1, 1, 64'h55, 8'hAA, 0, 1, 0,    7'd0, 1, 64'h0,  8'h00, 0);
    vecs[10] = mk(1, 1, 64'h66, 8'hFF, 1, 1, 1,    7'd1, 1, 64'h55, 8'hAA, 1);
    vecs[11] = mk(0, 0, 64'h0,  8'h00, 0, 1, 1,    7'd1, 1, 64'h66, 8'hFF, 1);
    vecs[12] = mk(0, 0, 64'h0,  8'h00, 1, 1, 1,    7'd1, 1, 64'h66, 8'hFF, 1);
    vecs[13] = mk(0, 0, 64'h0,  8'h00, 0, 1, 0,    7'd0, 1, 64'h0,  8'h00, 0);

    // reset state
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 64'h0, 8'h00, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_tready", 128'(s_axis_tready), 128'(0));
    check("rst_rready", 128'(u_fifo_rready), 128'(0));
    check("rst_level",  128'(u_fifo_level),  128'(0));
    check("rst_err",    128'(u_rd_err),      128'(0));
    check("rst_afull",  128'(u_fifo_afull),  128'(0));
    drive(1'b0, 1'b0, 64'h0, 8'h00, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rel_tready_before_edge", 128'(s_axis_tready), 128'(0));
    @(posedge clk);

    // vector table: basic order, head fields, empty pop, simultaneous push/pop
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].k, vecs[i].r);
      #1;
      check($sformatf("v%0d_tready", i), 128'(s_axis_tready), 128'(vecs[i].e_tready));
      check($sformatf("v%0d_rready", i), 128'(u_fifo_rready), 128'(vecs[i].e_rready));
      check($sformatf("v%0d_level", i),  128'(u_fifo_level),  128'(vecs[i].e_level));
      check($sformatf("v%0d_err", i),    128'(u_rd_err),      128'(vecs[i].e_err));
      check($sformatf("v%0d_afull", i),  128'(u_fifo_afull),  128'(0));
      if (vecs[i].e_rready)
        check($sformatf("v%0d_head", i), 128'({u_fifo_rlast, u_fifo_rkeep, u_fifo_rdata}),
              128'({vecs[i].e_l, vecs[i].e_k, vecs[i].e_d}));
      @(posedge clk);
    end
    m_err = 1'b1;

    // fill to full from a non-zero pointer, reject the 65th beat, drain through the wrap
    for (int i = 0; i < DEPTH; i++) step(1'b1, i == DEPTH-1, 64'(i) + 64'h1000, 8'(i), 1'b0);
    step(1'b1, 1'b1, 64'hDEAD, 8'hFF, 1'b0);
    step(1'b0, 1'b0, 64'h0, 8'h00, 1'b0);
    drain();

    // steady level 10 with a push and a pop every cycle
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 64'(i) + 64'h2000, 8'hF0, 1'b0);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b1, 64'(i) + 64'h3000, 8'(i * 3), 1'b1);
    drain();

    // four beats without tlast, then the closing beat
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 64'(i) + 64'h4000, 8'hFF, 1'b0);
    step(1'b1, 1'b1, 64'h4004, 8'h0F, 1'b0);
    step(1'b0, 1'b0, 64'h0, 8'h00, 1'b0);
    drain();

    // reset two beats into a five-beat packet
    step(1'b1, 1'b0, 64'h5000, 8'hFF, 1'b0);
    step(1'b1, 1'b0, 64'h5001, 8'hFF, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 64'h0, 8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_level",  128'(u_fifo_level),  128'(0));
    check("mid_rst_rready", 128'(u_fifo_rready), 128'(0));
    check("mid_rst_tready", 128'(s_axis_tready), 128'(0));
    check("mid_rst_err",    128'(u_rd_err),      128'(0));
    exp_q.delete();
    m_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    step(1'b1, 1'b0, 64'hA1, 8'h11, 1'b0);
    step(1'b1, 1'b0, 64'hA2, 8'h22, 1'b0);
    step(1'b1, 1'b1, 64'hA3, 8'h33, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/s_axis_pkt.md
S_AXIS_PKT -- requirements
Module: s_axis_pkt

Interface
REQ-001 Parameter S_AXIS_DATA_BYTES, default 8, SHALL set the tdata width to 8*S_AXIS_DATA_BYTES bits and the tkeep width to S_AXIS_DATA_BYTES bits.
REQ-002 Parameter FIFO_DEPTH, default 64, SHALL set the number of stored beats; legal values are powers of 2, minimum 4.
REQ-003 Parameter FIFO_AW, default 6, SHALL equal log2(FIFO_DEPTH) and sets the pointer width.
REQ-004 Parameter AFULL_LVL, default 56, SHALL set the level at which u_fifo_afull asserts; legal range is 1..FIFO_DEPTH.
REQ-005 s_axis_aclk  in  1  is the single clock for all logic.
REQ-006 s_axis_aresetn  in  1  is the reset, asynchronous and active-low.
REQ-007 s_axis_tvalid  in  1  indicates the upstream beat is valid.
REQ-008 s_axis_tlast  in  1  marks the last beat of a packet.
REQ-009 s_axis_tdata  in  8*S_AXIS_DATA_BYTES  is the beat payload.
REQ-010 s_axis_tstrb  in  S_AXIS_DATA_BYTES  is accepted and ignored.
REQ-011 s_axis_tkeep  in  S_AXIS_DATA_BYTES  carries byte qualifiers and is stored with the beat.
REQ-012 s_axis_tready  out  1  indicates the block accepts a beat.
REQ-013 u_fifo_ren  in  1  pops the head beat.
REQ-014 u_fifo_rready  out  1  indicates the head beat is poppable.
REQ-015 u_fifo_rdata / u_fifo_rkeep / u_fifo_rlast  out  8*S_AXIS_DATA_BYTES / S_AXIS_DATA_BYTES / 1  present the head beat fields.
REQ-016 u_fifo_level  out  FIFO_AW+1  gives the current stored-beat count.
REQ-017 u_fifo_afull  out  1  asserts when u_fifo_level >= AFULL_LVL.
REQ-018 u_rd_err  out  1  is a sticky flag set by a pop attempt while u_fifo_rready=0.

Function
REQ-019 Storage SHALL hold {tlast, tkeep, tdata} per beat in FIFO order; depth is exactly FIFO_DEPTH.
REQ-020 Write SHALL occur when s_axis_tvalid & s_axis_tready; s_axis_tready = ~full, registered-free, combinational from state.
REQ-021 Read side SHALL be first-word-fall-through: head fields are valid combinationally whenever u_fifo_rready=1, and a pop occurs when u_fifo_ren & u_fifo_rready.
REQ-022 Latency: a beat written at edge N SHALL be visible on u_fifo_r* with u_fifo_rready=1 in the cycle after edge N (streaming mode).
REQ-023 Pointers SHALL be FIFO_AW+1 bits wide, using the wrap bit for the full/empty distinction, and SHALL wrap from FIFO_DEPTH-1 to 0 without loss.
REQ-024 A simultaneous write and pop SHALL leave the level unchanged; at full, tready=0 so no write occurs; at empty, the pop is ignored and sets u_rd_err.
REQ-025 u_fifo_level SHALL update on the same edge as the write or pop; u_fifo_afull is derived from the registered level.
REQ-026 u_rd_err SHALL be cleared only by reset.

Reset
REQ-027 While s_axis_aresetn=0, pointers, level, packet count and u_rd_err SHALL be 0; u_fifo_rready=0; s_axis_tready=0.
REQ-028 s_axis_tready SHALL rise in the first cycle after reset deassertion.
REQ-029 Reset asserted mid-packet SHALL discard all stored beats, and no partial packet is reported afterwards.
REQ-030 Storage array contents need not be reset.

Configuration
REQ-031 Macro S_AXIS_PKT_MODE_EN, when defined, SHALL add a packet counter (FIFO_AW+1 bits): it increments on a write with tlast=1, decrements on a pop with rlast=1, and is unchanged when both occur together.
REQ-032 With S_AXIS_PKT_MODE_EN defined, u_fifo_rready SHALL equal ~empty & (pkt_cnt != 0 | full), so a full FIFO with no tlast releases beats to avoid deadlock.
REQ-033 Without S_AXIS_PKT_MODE_EN, no packet counter SHALL exist, and u_fifo_rready SHALL equal ~empty (streaming mode).

Verification
REQ-034 Reset, then write 3 beats (tdata 0x11,0x22,0x33, tlast on the 3rd) with no pops -> u_fifo_level=3, and the head reads 0x11, then 0x22, then 0x33 with rlast=1 on 0x33.
REQ-035 Write 64 beats with no pops (defaults) -> s_axis_tready=0 after the 64th, u_fifo_afull=1 from level 56, and the 65th beat is not accepted.
REQ-036 Keep the FIFO at level 10 while writing and popping every cycle for 200 cycles -> level stays 10, data order is preserved, and the pointers wrap cleanly.
REQ-037 Pop with the FIFO empty -> no pointer change, and u_rd_err=1 and stays 1 until reset.
REQ-038 With S_AXIS_PKT_MODE_EN defined, write 4 beats without tlast -> u_fifo_rready=0; write a 5th beat with tlast -> u_fifo_rready=1 next cycle.
REQ-039 Assert reset after 2 beats of a 5-beat packet -> level=0 and rready=0, and post-reset beats read back without stale data.
